// File: rtl/alu_op_pkg.sv
// Shared opcode definitions for the pipelined ALU, used by the decode and by the benches.
package alu_op_pkg;

  typedef enum logic [3:0] {
    OP_MOV  = 4'd2,
    OP_INC  = 4'd3,
    OP_DEC  = 4'd4,
    OP_NOT  = 4'd5,
    OP_NOR  = 4'd6,
    OP_XOR  = 4'd7,
    OP_XNOR = 4'd8,
    OP_GT   = 4'd9,
    OP_LT   = 4'd10,
    OP_EQ   = 4'd11
  } alu_op_e;

endpackage

// File: rtl/alu_op_core.sv
// Combinational ALU datapath: result, wrap flag, zero flag and undefined-opcode flag.
module alu_op_core
  import alu_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  input  logic             signed_cmp,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] One     = WIDTH'(1);
  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [WIDTH-2:0] Pad     = '0;

  logic gt;
  logic lt;

  always_comb begin
    if (signed_cmp) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
  end

  always_comb begin
    s        = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (ctrl)
      OP_MOV:  s = a;
      OP_INC: begin
        s        = a + One;
        overflow = (a == AllOnes);
      end
      OP_DEC: begin
        s        = a - One;
        overflow = (a == '0);
      end
      OP_NOT:  s = ~a;
      OP_NOR:  s = ~(a | b);
      OP_XOR:  s = a ^ b;
      OP_XNOR: s = ~(a ^ b);
      OP_GT:   s = {Pad, gt};
      OP_LT:   s = {Pad, lt};
      OP_EQ:   s = {Pad, (a == b)};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (s == '0);

endmodule

// File: rtl/alu_op_pipe.sv
// Two-stage ALU pipeline: S1 holds operands, S2 holds the computed result and flags.
module alu_op_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  input  logic             signed_cmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  input  logic             sticky_clr,
  output logic             ovf_sticky
);

  logic             adv;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [3:0]       s1_ctrl_q;
  logic             s1_signed_q;

  logic [WIDTH-1:0] core_s;
  logic             core_overflow;
  logic             core_zero;
  logic             core_illegal;

  // Whole pipe moves in lockstep; a stall freezes bubbles as well as data.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ctrl_q   <= '0;
      s1_signed_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q      <= a;
        s1_b_q      <= b;
        s1_ctrl_q   <= ctrl;
        s1_signed_q <= signed_cmp;
      end
    end
  end

  alu_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a          (s1_a_q),
    .b          (s1_b_q),
    .ctrl       (s1_ctrl_q),
    .signed_cmp (s1_signed_q),
    .s          (core_s),
    .overflow   (core_overflow),
    .zero       (core_zero),
    .illegal    (core_illegal)
  );

  // Result registers only load real results so they keep the last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        s        <= core_s;
        overflow <= core_overflow;
        zero     <= core_zero;
        illegal  <= core_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && overflow) begin
      ovf_sticky <= 1'b1;
    end else if (sticky_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/alu_op_pipe.md
ALU_OP_PIPE -- requirements
Module: alu_op_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/ctrl/signed_cmp is valid this cycle.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 ctrl  input  4  operation code.
REQ-009 signed_cmp  input  1  1 = GT/LT compare two's-complement; 0 = unsigned.
REQ-010 out_valid  output  1  s and flags hold a result.
REQ-011 out_ready  input  1  downstream takes result this cycle.
REQ-012 s  output  WIDTH  result.
REQ-013 overflow  output  1  carry/borrow of this result.
REQ-014 zero  output  1  s == 0.
REQ-015 illegal  output  1  ctrl was an undefined code.
REQ-016 sticky_clr  input  1  clears ovf_sticky.
REQ-017 ovf_sticky  output  1  set by any delivered result with overflow = 1.

Function
REQ-018 Opcodes: 2 s=a; 3 s=a+1; 4 s=a-1; 5 s=~a; 6 s=~(a|b); 7 s=a^b; 8 s=~(a^b); 9 s=(a>b); 10 s=(a<b); 11 s=(a==b).
REQ-019 Compare ops (9-11) drive s = {WIDTH-1 zeros, result bit}.
REQ-020 Codes 0,1,12-15: s=0, illegal=1, overflow=0; all defined codes give illegal=0.
REQ-021 Arithmetic modulo 2^WIDTH; overflow=1 only for op 3 with a = all-ones (s wraps to 0) or op 4 with a = 0 (s wraps to all-ones); 0 for all other ops.
REQ-022 signed_cmp affects only ops 9 and 10; op 11 is sign-independent.
REQ-023 Two register stages: S1 captures a/b/ctrl/signed_cmp; S2 captures computed s and flags; latency 2 cycles from accepted input to out_valid with no backpressure.
REQ-024 Advance enable adv = !out_valid || out_ready; in_ready = adv; both stages load only when adv = 1.
REQ-025 Transfer into S1 occurs when in_valid && in_ready; S1 valid bit loads in_valid when adv.
REQ-026 When adv = 0, S1 and S2 contents and outputs hold stable; a bubble in S1 is not collapsed during stall.
REQ-027 Throughput one result per cycle while out_ready = 1 continuously.
REQ-028 s/overflow/zero/illegal are don't-care when out_valid = 0 but hold last loaded values (no X).
REQ-029 Result delivered when out_valid && out_ready; ovf_sticky sets on that cycle if overflow = 1.
REQ-030 sticky_clr in same cycle as a delivered overflow: set wins, ovf_sticky = 1 next cycle.
REQ-031 sticky_clr without delivered overflow: ovf_sticky = 0 next cycle.

Reset
REQ-032 rst_n low asynchronously forces S1/S2 valid = 0, out_valid = 0, s = 0, overflow = 0, zero = 0, illegal = 0, ovf_sticky = 0.
REQ-033 in_ready = 1 during and immediately after reset (follows REQ-024).
REQ-034 Reset mid-operation discards all in-flight results; no result emerges after deassertion without new input.

Structure
REQ-035 Opcode constants (OP_MOV..OP_EQ) live in shared package alu_op_pkg for reuse by ALU decode and benches.
REQ-036 Combinational datapath (REQ-018..022) in sub-module alu_op_core, parametrised by WIDTH; alu_op_pipe holds only registers and handshake.

Verification (WIDTH=8)
REQ-037 Ops 2..11 back-to-back, a=0x5A, b=0x3C, out_ready=1 -> results 5A,5B,59,A5,81,66,99,01,00,00 on consecutive cycles starting 2 cycles after first accept.
REQ-038 op 3 a=0xFF -> s=0x00, overflow=1, zero=1; op 4 a=0x00 -> s=0xFF, overflow=1; ovf_sticky=1 after first delivery.
REQ-039 op 9 a=0x80, b=0x01: signed_cmp=0 -> s=0x01; signed_cmp=1 -> s=0x00; op 10 same operands opposite results.
REQ-040 Stream 4 ops, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, s stable, no result lost or duplicated, order preserved.
REQ-041 ctrl=0xE -> s=0, illegal=1; sticky_clr coincident with overflow delivery -> ovf_sticky stays 1; rst_n pulse with 2 ops in flight -> out_valid=0, no output after release.
